// File: rtl/rgb_color_seq.sv
// RGB colour sequencer: debounced buttons step a writable palette or force a default colour, output jumps or fades.
// Latency: button edge to RGBcolor is 4+DEB_CYCLES clocks; palette write to RGBcolor is 2 clocks (FADE_DIV=0).
// Backpressure: none; the inputs are sampled every clock and the output is always valid.
module rgb_color_seq #(
    parameter int                   CH_W        = 8,
    parameter int                   NUM_COLORS  = 4,
    parameter int                   DEB_CYCLES  = 12000,
    parameter int                   FADE_DIV    = 0,
    parameter logic [3*CH_W-1:0]    DEFAULT_RGB = (3*CH_W)'(24'h5F5F5F)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      button,
    input  logic                            pal_we,
    input  logic [$clog2(NUM_COLORS)-1:0]   pal_addr,
    input  logic [3*CH_W-1:0]               pal_data,
    output logic [3*CH_W-1:0]               RGBcolor,
    output logic [$clog2(NUM_COLORS)-1:0]   color_idx,
    output logic                            busy
);

    localparam int RGB_W    = 3 * CH_W;
    localparam int IDX_W    = $clog2(NUM_COLORS);
    localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam int TICK_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int TICK_MAX = (FADE_DIV > 0) ? FADE_DIV - 1 : 0;

    // Reset palette levels: M is half scale, W is quarter scale.
    localparam logic [CH_W-1:0] CH_M = CH_W'((1 << (CH_W - 1)) - 1);
    localparam logic [CH_W-1:0] CH_W_LVL = CH_W'((1 << (CH_W - 2)) - 1);
    localparam logic [CH_W-1:0] CH_Z = '0;

    function automatic logic [RGB_W-1:0] pal_init(input int i);
        case (i)
            0:       return {CH_W_LVL, CH_W_LVL, CH_W_LVL};
            1:       return {CH_M, CH_Z, CH_Z};
            2:       return {CH_Z, CH_M, CH_Z};
            3:       return {CH_Z, CH_Z, CH_M};
            default: return '0;
        endcase
    endfunction

    logic [1:0]             sync1_q, sync1_d;
    logic [1:0]             sync2_q, sync2_d;
    logic [1:0]             deb_q, deb_d;
    logic [1:0]             deb_prev_q, deb_prev_d;
    logic [1:0][DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [RGB_W-1:0]       pal_q [NUM_COLORS];
    logic [RGB_W-1:0]       pal_d [NUM_COLORS];
    logic [RGB_W-1:0]       target_q, target_d;
    logic [RGB_W-1:0]       rgb_q, rgb_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic                   tick;

    // Two-flop synchronisers, then a per-bit run-length debounce of the synchronised value.
    always_comb begin
        sync1_d    = button;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        deb_prev_d = deb_q;
        deb_cnt_d  = '0;
        for (int b = 0; b < 2; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
                end
            end
        end
    end

    // Step the index on a debounced rise, apply palette writes, pick the target colour.
    // The override uses the delayed debounced bit so it shares the step path's latency.
    always_comb begin
        idx_d = idx_q;
        if (deb_q[0] && !deb_prev_q[0]) begin
            idx_d = idx_q + IDX_W'(1);
        end
        pal_d = pal_q;
        if (pal_we) begin
            pal_d[pal_addr] = pal_data;
        end
        target_d = deb_prev_q[1] ? DEFAULT_RGB : pal_q[idx_q];
    end

    // Output stage: copy the target, or walk each channel one LSB toward it on every fade tick.
    always_comb begin
        tick   = (FADE_DIV > 0) && (tick_q == TICK_W'(TICK_MAX));
        tick_d = tick_q + TICK_W'(1);
        if (FADE_DIV == 0 || tick) begin
            tick_d = '0;
        end
        rgb_d = rgb_q;
        if (FADE_DIV == 0) begin
            rgb_d = target_q;
        end else if (tick) begin
            for (int c = 0; c < 3; c++) begin
                if (rgb_q[c*CH_W +: CH_W] < target_q[c*CH_W +: CH_W]) begin
                    rgb_d[c*CH_W +: CH_W] = rgb_q[c*CH_W +: CH_W] + CH_W'(1);
                end else if (rgb_q[c*CH_W +: CH_W] > target_q[c*CH_W +: CH_W]) begin
                    rgb_d[c*CH_W +: CH_W] = rgb_q[c*CH_W +: CH_W] - CH_W'(1);
                end
            end
        end
    end

    // State registers with synchronous active-low reset; the palette reloads its default contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            deb_cnt_q  <= '0;
            idx_q      <= '0;
            target_q   <= '0;
            rgb_q      <= '0;
            tick_q     <= '0;
            for (int i = 0; i < NUM_COLORS; i++) begin
                pal_q[i] <= pal_init(i);
            end
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            deb_cnt_q  <= deb_cnt_d;
            idx_q      <= idx_d;
            target_q   <= target_d;
            rgb_q      <= rgb_d;
            tick_q     <= tick_d;
            pal_q      <= pal_d;
        end
    end

    assign RGBcolor  = rgb_q;
    assign color_idx = idx_q;
    assign busy      = (rgb_q != target_q);

endmodule

// File: tb/tb_rgb_color_seq.sv
// Bench for rgb_color_seq: an instant-output and a fading instance share stimulus.
// Directed table of button sequences, hand-written palette/fade/reset cases, then random stimulus.
// Both instances are compared every cycle against a latency-based behavioural model.
module tb_rgb_color_seq;

    localparam int          D   = 4;
    localparam int          FD  = 3;
    localparam logic [23:0] DEF = 24'h5F5F5F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  button;
    logic        pal_we;
    logic [1:0]  pal_addr;
    logic [23:0] pal_data;
    logic [23:0] rgb0, rgb3;
    logic [1:0]  idx0, idx3;
    logic        busy0, busy3;

    always #5 clk = ~clk;

    rgb_color_seq #(.CH_W(8), .NUM_COLORS(4), .DEB_CYCLES(D), .FADE_DIV(0), .DEFAULT_RGB(DEF)) u_dut (
        .clk(clk), .rst_n(rst_n), .button(button), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .RGBcolor(rgb0), .color_idx(idx0), .busy(busy0));

    rgb_color_seq #(.CH_W(8), .NUM_COLORS(4), .DEB_CYCLES(D), .FADE_DIV(FD), .DEFAULT_RGB(DEF)) u_fade (
        .clk(clk), .rst_n(rst_n), .button(button), .pal_we(pal_we), .pal_addr(pal_addr),
        .pal_data(pal_data), .RGBcolor(rgb3), .color_idx(idx3), .busy(busy3));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Values held after the most recent clock edge.
    logic [23:0] m_pal [4];
    logic [1:0]  m_idx;
    logic [23:0] m_tgt, m_rgb0, m_rgb3;
    logic [1:0]  m_deb;       // debounced buttons after last edge
    logic [1:0]  m_deb_old;   // debounced buttons one edge earlier
    logic [1:0]  hist [$];    // raw button samples, hist[0] = newest edge
    int          m_cyc;       // edges since reset release

    function automatic logic [23:0] reset_entry(input int i);
        logic [7:0] m;
        logic [7:0] w;
        m = 8'((1 << 7) - 1);
        w = 8'((1 << 6) - 1);
        case (i)
            0: return {w, w, w};
            1: return {m, 8'd0, 8'd0};
            2: return {8'd0, m, 8'd0};
            3: return {8'd0, 8'd0, m};
            default: return 24'd0;
        endcase
    endfunction

    function automatic logic [23:0] toward(input logic [23:0] cur, input logic [23:0] tgt);
        logic [23:0] r;
        int a;
        int t;
        r = cur;
        for (int c = 0; c < 3; c++) begin
            a = int'(cur[c*8 +: 8]);
            t = int'(tgt[c*8 +: 8]);
            if (a < t) a = a + 1;
            else if (a > t) a = a - 1;
            r[c*8 +: 8] = 8'(a);
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [1:0]  new_deb;
        logic [1:0]  new_idx;
        logic [23:0] new_tgt;
        logic [23:0] new_rgb3;
        bit          all_diff;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_pal[i] = reset_entry(i);
            m_idx = 0; m_tgt = 0; m_rgb0 = 0; m_rgb3 = 0;
            m_deb = 0; m_deb_old = 0; m_cyc = 0;
            hist.delete();
            repeat (D + 2) hist.push_back(2'b00);
            return;
        end
        hist.push_front(button);
        void'(hist.pop_back());
        // A button state is accepted once D consecutive synchronised samples
        // (raw samples two edges old) all disagree with the current state.
        new_deb = m_deb;
        for (int b = 0; b < 2; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++) if (hist[j][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) new_deb[b] = ~m_deb[b];
        end
        new_idx  = (m_deb[0] && !m_deb_old[0]) ? 2'((int'(m_idx) + 1) % 4) : m_idx;
        new_tgt  = m_deb_old[1] ? DEF : m_pal[m_idx];
        new_rgb3 = ((m_cyc % FD) == FD - 1) ? toward(m_rgb3, m_tgt) : m_rgb3;
        m_rgb0    = m_tgt;
        m_rgb3    = new_rgb3;
        m_tgt     = new_tgt;
        m_idx     = new_idx;
        m_deb_old = m_deb;
        m_deb     = new_deb;
        if (pal_we) m_pal[pal_addr] = pal_data;
        m_cyc++;
    endtask

    task automatic chk_all();
        check("cyc_rgb_inst", rgb0, m_rgb0);
        check("cyc_idx_inst", idx0, m_idx);
        check("cyc_busy_inst", busy0, m_rgb0 != m_tgt);
        check("cyc_rgb_fade", rgb3, m_rgb3);
        check("cyc_idx_fade", idx3, m_idx);
        check("cyc_busy_fade", busy3, m_rgb3 != m_tgt);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk_all();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        string       name;
        logic [1:0]  btn;
        int          cycles;
        logic [23:0] rgb;
        logic [1:0]  idx;
        logic        busy;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input string n, input logic [1:0] b, input int c,
                       input logic [23:0] r, input logic [1:0] i, input logic bz);
        vec_t v;
        v.name = n; v.btn = b; v.cycles = c; v.rgb = r; v.idx = i; v.busy = bz;
        tbl.push_back(v);
    endtask

    int g_at, r_at, b_at;
    bit seen_busy;
    int hold0, hold1;

    initial begin
        add("reset_out",   2'b00,  2, 24'h3F3F3F, 2'd0, 1'b0);
        add("press1_pre",  2'b01,  8, 24'h3F3F3F, 2'd1, 1'b1);
        add("press1",      2'b01,  1, 24'h7F0000, 2'd1, 1'b0);
        add("press1_hold", 2'b01,  1, 24'h7F0000, 2'd1, 1'b0);
        add("rel1",        2'b00, 10, 24'h7F0000, 2'd1, 1'b0);
        add("press2",      2'b01, 10, 24'h007F00, 2'd2, 1'b0);
        add("rel2",        2'b00, 10, 24'h007F00, 2'd2, 1'b0);
        add("press3",      2'b01, 10, 24'h00007F, 2'd3, 1'b0);
        add("rel3",        2'b00, 10, 24'h00007F, 2'd3, 1'b0);
        add("press4_wrap", 2'b01, 10, 24'h3F3F3F, 2'd0, 1'b0);
        add("rel4",        2'b00, 10, 24'h3F3F3F, 2'd0, 1'b0);
        add("glitch",      2'b01,  2, 24'h3F3F3F, 2'd0, 1'b0);
        add("glitch_gap",  2'b00, 12, 24'h3F3F3F, 2'd0, 1'b0);
        add("ovr_on",      2'b10, 10, 24'h5F5F5F, 2'd0, 1'b0);
        add("ovr_step",    2'b11, 10, 24'h5F5F5F, 2'd1, 1'b0);
        add("ovr_steprel", 2'b10, 10, 24'h5F5F5F, 2'd1, 1'b0);
        add("ovr_off",     2'b00, 10, 24'h7F0000, 2'd1, 1'b0);
        add("press5",      2'b01, 10, 24'h007F00, 2'd2, 1'b0);
        add("rel5",        2'b00, 10, 24'h007F00, 2'd2, 1'b0);
        add("press6",      2'b01, 10, 24'h00007F, 2'd3, 1'b0);
        add("rel6",        2'b00, 10, 24'h00007F, 2'd3, 1'b0);
        add("press7",      2'b01, 10, 24'h3F3F3F, 2'd0, 1'b0);
        add("rel7",        2'b00, 10, 24'h3F3F3F, 2'd0, 1'b0);

        rst_n = 1'b0; button = 2'b00; pal_we = 1'b0; pal_addr = 2'd0; pal_data = 24'd0;
        repeat (3) cyc();
        check("rst_rgb", rgb0, 24'h0);
        check("rst_idx", idx0, 2'd0);
        check("rst_busy", busy0, 1'b0);
        check("rst_fade_rgb", rgb3, 24'h0);
        check("rst_fade_busy", busy3, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            button = tbl[k].btn;
            repeat (tbl[k].cycles) cyc();
            check({tbl[k].name, "_rgb"}, rgb0, tbl[k].rgb);
            check({tbl[k].name, "_idx"}, idx0, tbl[k].idx);
            check({tbl[k].name, "_busy"}, busy0, tbl[k].busy);
        end

        // Palette write to the selected entry: target one edge later, output two edges later.
        pal_we = 1'b1; pal_addr = 2'd0; pal_data = 24'h123456;
        cyc();
        pal_we = 1'b0;
        check("wr_n_rgb", rgb0, 24'h3F3F3F);
        cyc();
        check("wr_n1_rgb", rgb0, 24'h3F3F3F);
        check("wr_n1_busy", busy0, 1'b1);
        cyc();
        check("wr_n2_rgb", rgb0, 24'h123456);
        check("wr_n2_busy", busy0, 1'b0);
        pal_we = 1'b1; pal_addr = 2'd2; pal_data = 24'hABCDEF;
        cyc();
        pal_we = 1'b0;
        repeat (3) cyc();
        check("wr_other_rgb", rgb0, 24'h123456);

        // Fade: reset restores the palette, fading copy ramps up, then a full 3F3F3F -> 7F0000 fade.
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        check("pal_restore_rgb", rgb0, 24'h3F3F3F);
        repeat (200) cyc();
        check("fade_up_rgb", rgb3, 24'h3F3F3F);
        check("fade_up_busy", busy3, 1'b0);
        button = 2'b01;
        g_at = -1; r_at = -1; b_at = -1; seen_busy = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            if (i == 11) button = 2'b00;
            cyc();
            if (busy3) seen_busy = 1'b1;
            if (g_at < 0 && rgb3[15:0] == 16'h0) g_at = i;
            if (r_at < 0 && rgb3[23:16] == 8'h7F) r_at = i;
            if (b_at < 0 && seen_busy && !busy3) b_at = i;
            if (b_at >= 0 && i > b_at + 5) break;
        end
        check("fade_r_after_g", 32'(r_at - g_at), 32'(FD));
        check("fade_busy_drop", 32'(b_at), 32'(r_at));
        check("fade_duration", 32'((r_at - 8 >= 64*FD - FD) && (r_at - 8 <= 64*FD + FD)), 32'd1);
        check("fade_end_rgb", rgb3, 24'h7F0000);

        // Reset mid-fade after corrupting entry 0: everything clears on the next edge.
        pal_we = 1'b1; pal_addr = 2'd0; pal_data = 24'hABCDEF;
        cyc();
        pal_we = 1'b0;
        button = 2'b01;
        repeat (10) cyc();
        button = 2'b00;
        repeat (30) cyc();
        check("midfade_busy", busy3, 1'b1);
        rst_n = 1'b0;
        cyc();
        check("midrst_fade_rgb", rgb3, 24'h0);
        check("midrst_fade_idx", idx3, 2'd0);
        check("midrst_fade_busy", busy3, 1'b0);
        check("midrst_inst_rgb", rgb0, 24'h0);
        check("midrst_inst_idx", idx0, 2'd0);
        rst_n = 1'b1;
        repeat (2) cyc();
        check("pal_restore2_rgb", rgb0, 24'h3F3F3F);

        // Random stimulus: button runs of random length, palette writes, occasional reset.
        hold0 = 0; hold1 = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold0 == 0) begin
                button[0] = 1'($urandom_range(0, 1));
                hold0 = int'($urandom_range(1, 12));
            end else hold0--;
            if (hold1 == 0) begin
                button[1] = 1'($urandom_range(0, 1));
                hold1 = int'($urandom_range(1, 30));
            end else hold1--;
            pal_we   = ($urandom_range(0, 7) == 0);
            pal_addr = 2'($urandom_range(0, 3));
            pal_data = 24'($urandom);
            rst_n    = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
